// File: rtl/mdu_iter_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_iter_pkg;

    localparam logic MDU_OP_MUL = 1'b0;
    localparam logic MDU_OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
module mdu_step
    import mdu_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 op_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH:0]       rem_i,
    input  logic [WIDTH-1:0]     mag_i,
    output logic [2*WIDTH-1:0]   acc_o,
    output logic [WIDTH:0]       rem_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        // Multiply: acc = {partial product, remaining multiplier bits}, LSB first.
        sum     = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc_i[0]}} & mag_i};
        // Divide: dividend bits shift out of acc MSB-first into the remainder.
        shifted = {rem_i, acc_i[WIDTH-1]};
        diff    = shifted - {2'b00, mag_i};
        if (op_i == MDU_OP_MUL) begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
            rem_o = rem_i;
        end else begin
            acc_o = {{WIDTH{1'b0}}, acc_i[WIDTH-2:0], ~diff[WIDTH+1]};
            rem_o = diff[WIDTH+1] ? shifted[WIDTH:0] : diff[WIDTH:0];
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit for EXE; WIDTH steps on magnitudes, then a sign fix-up.
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             mdu_start,
    input  logic             mdu_op,
    input  logic             mdu_signed,
    input  logic [WIDTH-1:0] mdu_src1,
    input  logic [WIDTH-1:0] mdu_src2,
    input  logic             mdu_cancel,
    output logic             mdu_busy,
    output logic             mdu_done,
    output logic [WIDTH-1:0] mdu_hi,
    output logic [WIDTH-1:0] mdu_lo,
    output logic             mdu_div_zero
);

    function automatic logic [WIDTH-1:0] fix_sign(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] fix_sign2(input logic [2*WIDTH-1:0] x, input logic neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_q, op_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic               dzp_q, dzp_d;
    logic [WIDTH-1:0]   mag_q, mag_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               dz_q, dz_d;

    logic               s1, s2;
    logic [WIDTH-1:0]   m1, m2;
    logic [2*WIDTH-1:0] step_acc;
    logic [WIDTH:0]     step_rem;

    assign s1 = mdu_signed & mdu_src1[WIDTH-1];
    assign s2 = mdu_signed & mdu_src2[WIDTH-1];
    assign m1 = fix_sign(mdu_src1, s1);
    assign m2 = fix_sign(mdu_src2, s2);

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .op_i  (op_q),
        .acc_i (acc_q),
        .rem_i (rem_q),
        .mag_i (mag_q),
        .acc_o (step_acc),
        .rem_o (step_rem)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dzp_d   = dzp_q;
        mag_d   = mag_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE: begin
                if (mdu_start && !mdu_cancel) begin
                    op_d    = mdu_op;
                    qneg_d  = s1 ^ s2;
                    rneg_d  = s1;
                    dzp_d   = (mdu_op == MDU_OP_DIV) && (m2 == '0);
                    mag_d   = (mdu_op == MDU_OP_DIV) ? m2 : m1;
                    acc_d   = {{WIDTH{1'b0}}, (mdu_op == MDU_OP_DIV) ? m1 : m2};
                    rem_d   = '0;
                    cnt_d   = CNT_W'(WIDTH - 1);
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (mdu_cancel) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = step_acc;
                    rem_d = step_rem;
                    if (cnt_q == '0) state_d = S_FIX;
                    else             cnt_d   = cnt_q - 1'b1;
                end
            end
            S_FIX: begin
                if (mdu_cancel) begin
                    state_d = S_IDLE;
                end else begin
                    if (op_q == MDU_OP_MUL) begin
                        {hi_d, lo_d} = fix_sign2(acc_q, qneg_q);
                        dz_d         = 1'b0;
                    end else begin
                        // Remainder fix-up of a zero divisor already yields the raw dividend.
                        hi_d = fix_sign(rem_q[WIDTH-1:0], rneg_q);
                        lo_d = dzp_q ? {WIDTH{1'b1}} : fix_sign(acc_q[WIDTH-1:0], qneg_q);
                        dz_d = dzp_q;
                    end
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= MDU_OP_MUL;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dzp_q   <= 1'b0;
            mag_q   <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dzp_q   <= dzp_d;
            mag_q   <= mag_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
        end
    end

    assign mdu_busy     = (state_q == S_CALC) || (state_q == S_FIX);
    assign mdu_done     = (state_q == S_DONE);
    assign mdu_hi       = hi_q;
    assign mdu_lo       = lo_q;
    assign mdu_div_zero = dz_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Randomised and directed checks of mdu_iter against an arithmetic reference model.
module tb_mdu_iter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         resetn;
    logic         mdu_start;
    logic         mdu_op;
    logic         mdu_signed;
    logic [W-1:0] mdu_src1;
    logic [W-1:0] mdu_src2;
    logic         mdu_cancel;
    logic         mdu_busy;
    logic         mdu_done;
    logic [W-1:0] mdu_hi;
    logic [W-1:0] mdu_lo;
    logic         mdu_div_zero;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(W), .CNT_W(6)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .mdu_start    (mdu_start),
        .mdu_op       (mdu_op),
        .mdu_signed   (mdu_signed),
        .mdu_src1     (mdu_src1),
        .mdu_src2     (mdu_src2),
        .mdu_cancel   (mdu_cancel),
        .mdu_busy     (mdu_busy),
        .mdu_done     (mdu_done),
        .mdu_hi       (mdu_hi),
        .mdu_lo       (mdu_lo),
        .mdu_div_zero (mdu_div_zero)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero like DIV.
    function automatic void model(input logic op, input logic sg, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] h,
                                  output logic [W-1:0] l, output logic z);
        longint sa, sb, p;
        logic [63:0] up;
        z = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!op) begin
            if (sg) begin p = sa * sb; {h, l} = p; end
            else begin up = {32'b0, a} * {32'b0, b}; {h, l} = up; end
        end else if (b == 0) begin
            l = '1; h = a; z = 1'b1;
        end else if (sg) begin
            l = 32'(sa / sb);
            h = 32'(sa % sb);
        end else begin
            l = a / b;
            h = a % b;
        end
    endfunction

    function automatic logic [W-1:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom());
        endcase
    endfunction

    task automatic drive(input logic st, input logic op, input logic sg,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        mdu_start = st; mdu_op = op; mdu_signed = sg; mdu_src1 = a; mdu_src2 = b;
    endtask

    task automatic watch(input int n, output int dn);
        dn = 0;
        repeat (n) begin
            @(negedge clk);
            if (mdu_done) dn++;
        end
    endtask

    // Full operation: checks latency, busy span, one-cycle done and results.
    task automatic run_op(input logic op, input logic sg, input logic [W-1:0] a,
                          input logic [W-1:0] b, output logic [W-1:0] eh, output logic [W-1:0] el);
        logic ez;
        int k, busy_n;
        bit got;
        model(op, sg, a, b, eh, el, ez);
        @(negedge clk); drive(1'b1, op, sg, a, b);
        @(negedge clk); mdu_start = 1'b0;
        k = 1; busy_n = 0; got = 1'b0;
        while (!got && k < 100) begin
            if (mdu_done) got = 1'b1;
            else begin
                if (mdu_busy) busy_n++;
                @(negedge clk); k++;
            end
        end
        chk("done_seen", 64'(got), 64'd1);
        chk("latency", 64'(k), 64'(W + 2));
        chk("busy_cycles", 64'(busy_n), 64'(W + 1));
        chk("hi", 64'(mdu_hi), 64'(eh));
        chk("lo", 64'(mdu_lo), 64'(el));
        chk("div_zero", 64'(mdu_div_zero), 64'(ez));
        @(negedge clk);
        chk("done_pulse", 64'(mdu_done), 64'd0);
    endtask

    initial begin
        logic [W-1:0] eh, el, ph, pl;
        int dn, k;
        resetn = 1'b0; mdu_cancel = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(mdu_busy), 64'd0);
        chk("rst_done", 64'(mdu_done), 64'd0);
        chk("rst_hi", 64'(mdu_hi), 64'd0);
        chk("rst_lo", 64'(mdu_lo), 64'd0);
        chk("rst_dz", 64'(mdu_div_zero), 64'd0);
        resetn = 1'b1;

        run_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'h0000_0005, eh, el);
        chk("tp1_hi", 64'(mdu_hi), 64'hFFFF_FFFF);
        chk("tp1_lo", 64'(mdu_lo), 64'hFFFF_FFF1);
        run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, eh, el);
        chk("tp2_hi", 64'(mdu_hi), 64'hFFFF_FFFE);
        run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, eh, el);
        chk("tp3_lo", 64'(mdu_lo), 64'hFFFF_FFFD);
        run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, eh, el);
        chk("tp3_ovf_lo", 64'(mdu_lo), 64'h8000_0000);
        run_op(1'b1, 1'b0, 32'h0000_0064, 32'h0, eh, el);
        chk("tp4_dz", 64'(mdu_div_zero), 64'd1);
        run_op(1'b1, 1'b1, 32'hFFFF_FF9C, 32'h0, eh, el);
        run_op(1'b1, 1'b0, 32'h0000_0064, 32'h7, eh, el);

        for (int i = 0; i < 40; i++)
            run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_opnd(), rnd_opnd(), eh, el);

        // Cancel mid-CALC, ten cycles after the start cycle.
        run_op(1'b0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, ph, pl);
        @(negedge clk); drive(1'b1, 1'b1, 1'b0, 32'd1000, 32'd3);
        @(negedge clk); mdu_start = 1'b0;
        repeat (9) @(negedge clk);
        mdu_cancel = 1'b1;
        @(negedge clk); mdu_cancel = 1'b0;
        chk("cancel_busy", 64'(mdu_busy), 64'd0);
        watch(40, dn);
        chk("cancel_nodone", 64'(dn), 64'd0);
        chk("cancel_hi", 64'(mdu_hi), 64'(ph));
        chk("cancel_lo", 64'(mdu_lo), 64'(pl));

        // Cancel in the fix-up cycle must not commit results.
        @(negedge clk); drive(1'b1, 1'b1, 1'b0, 32'h0000_0064, 32'h0);
        @(negedge clk); mdu_start = 1'b0;
        repeat (W) @(negedge clk);
        chk("fix_busy", 64'(mdu_busy), 64'd1);
        mdu_cancel = 1'b1;
        @(negedge clk); mdu_cancel = 1'b0;
        chk("fixcan_busy", 64'(mdu_busy), 64'd0);
        watch(40, dn);
        chk("fixcan_nodone", 64'(dn), 64'd0);
        chk("fixcan_lo", 64'(mdu_lo), 64'(pl));
        chk("fixcan_dz", 64'(mdu_div_zero), 64'd0);

        // Start and cancel together in IDLE.
        @(negedge clk); drive(1'b1, 1'b0, 1'b0, 32'd9, 32'd9); mdu_cancel = 1'b1;
        @(negedge clk); mdu_start = 1'b0; mdu_cancel = 1'b0;
        chk("stcan_busy", 64'(mdu_busy), 64'd0);
        watch(40, dn);
        chk("stcan_nodone", 64'(dn), 64'd0);
        chk("stcan_hi", 64'(mdu_hi), 64'(ph));

        // Starts during CALC and DONE are ignored; cancel in DONE has no effect.
        model(1'b0, 1'b1, 32'hFFFF_FF00, 32'h0000_0003, eh, el, ph[0]);
        @(negedge clk); drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FF00, 32'h0000_0003);
        @(negedge clk); mdu_start = 1'b0;
        repeat (4) @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 32'd77, 32'd5);
        @(negedge clk); mdu_start = 1'b0;
        k = 6; dn = 0;
        while (!mdu_done && k < 100) begin @(negedge clk); k++; end
        if (mdu_done) dn++;
        chk("proto_latency", 64'(k), 64'(W + 2));
        mdu_start = 1'b1; mdu_cancel = 1'b1;
        @(negedge clk); mdu_start = 1'b0; mdu_cancel = 1'b0;
        chk("proto_busy", 64'(mdu_busy), 64'd0);
        watch(40, k);
        dn += k;
        chk("proto_done_cnt", 64'(dn), 64'd1);
        chk("proto_hi", 64'(mdu_hi), 64'(eh));
        chk("proto_lo", 64'(mdu_lo), 64'(el));

        // Asynchronous reset in the middle of CALC.
        run_op(1'b0, 1'b0, 32'd5, 32'd7, eh, el);
        @(negedge clk); drive(1'b1, 1'b1, 1'b0, 32'd1000, 32'd7);
        @(negedge clk); mdu_start = 1'b0;
        repeat (6) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("arst_busy", 64'(mdu_busy), 64'd0);
        chk("arst_done", 64'(mdu_done), 64'd0);
        chk("arst_hi", 64'(mdu_hi), 64'd0);
        chk("arst_lo", 64'(mdu_lo), 64'd0);
        chk("arst_dz", 64'(mdu_div_zero), 64'd0);
        @(negedge clk); resetn = 1'b1;
        run_op(1'b1, 1'b1, 32'hFFFF_FC18, 32'd7, eh, el);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
